tlb_tag_cam: RTL and testbench

- **Purpose:** fully associative 8-entry tag/match stage for the TLB.
- **Lookup:** holds the virtual page numbers (VPNs) and valid bits, and compares a lookup VPN against all entries in one cycle. The hit index is registered, and that index drives the address of the downstream 8x24 TLB data RAM, which holds PFN and flags.
- **Refill:** picks the victim entry, writes its tag, and asserts the RAM write enable in the same cycle. The 24-bit refill data goes to the RAM directly, not through this block.

---
 rtl/tlb_pkg.sv | 27 ++
 rtl/tlb_prio_enc8.sv | 20 ++
 rtl/tlb_tag_cam.sv | 122 ++++++++++++
 tb/tb_tlb_tag_cam.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_pkg.sv
// Shared types for the TLB tag/match stage.
// Sizes here must agree with the external TLB data RAM.
package tlb_pkg;

    localparam int ENTRIES = 8;
    localparam int VPN_W   = 20;
    localparam int IDX_W   = 3;

    typedef logic [VPN_W-1:0] vpn_t;
    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic {
        IDLE,
        LOOK
    } state_t;

    typedef struct packed {
        logic valid;
        logic hit;
        idx_t idx;
    } res_t;

    function automatic idx_t idx_inc(input idx_t i);
        return i + idx_t'(1);
    endfunction

endpackage

// File: rtl/tlb_prio_enc8.sv
// Lowest-index-wins priority encoder over 8 requests.
// idx is 0 when no request is set.
module tlb_prio_enc8 (
    input  logic [7:0] req,
    output logic [2:0] idx,
    output logic       any
);

    always_comb begin
        idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (req[i]) begin
                idx = 3'(i);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/tlb_tag_cam.sv
// Fully associative 8-entry TLB tag CAM with round-robin refill.
// The registered hit index addresses the external TLB data RAM.
module tlb_tag_cam
    import tlb_pkg::*;
(
    input  logic             clk,
    input  logic             clrn,
    input  logic             inv_all,
    input  logic             lookup_valid,
    output logic             lookup_ready,
    input  logic [VPN_W-1:0] lookup_vpn,
    output logic             res_valid,
    output logic             res_hit,
    output logic [IDX_W-1:0] res_idx,
    input  logic             refill_valid,
    output logic             refill_ready,
    input  logic [VPN_W-1:0] refill_vpn,
    output logic [IDX_W-1:0] ram_addr,
    output logic             ram_we
);

    state_t               state_q;
    state_t               state_d;
    vpn_t                 tag_q [ENTRIES];
    logic [ENTRIES-1:0]   valid_q;
    idx_t                 rr_q;
    res_t                 res_q;

    logic                 refill_acc;
    logic                 lookup_acc;
    vpn_t                 key;
    logic [ENTRIES-1:0]   match;
    logic [ENTRIES-1:0]   free;
    idx_t                 match_idx;
    idx_t                 free_idx;
    logic                 match_any;
    logic                 free_any;
    idx_t                 victim;

    assign refill_ready = clrn && (state_q == IDLE) && !inv_all;
    assign refill_acc   = refill_valid && refill_ready;
    assign lookup_ready = clrn && !inv_all && !refill_acc;
    assign lookup_acc   = lookup_valid && lookup_ready;

    // Refill and lookup are never accepted together, so one
    // comparator bank serves both the hit and duplicate checks.
    assign key  = refill_acc ? refill_vpn : lookup_vpn;
    assign free = ~valid_q;

    always_comb begin
        match = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            match[i] = valid_q[i] && (tag_q[i] == key);
        end
    end

    tlb_prio_enc8 u_hit_enc (
        .req (match),
        .idx (match_idx),
        .any (match_any)
    );

    tlb_prio_enc8 u_free_enc (
        .req (free),
        .idx (free_idx),
        .any (free_any)
    );

    always_comb begin
        victim = rr_q;
        if (match_any) begin
            victim = match_idx;
        end else if (free_any) begin
            victim = free_idx;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: state_d = lookup_acc ? LOOK : IDLE;
            LOOK: state_d = lookup_acc ? LOOK : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q <= IDLE;
            valid_q <= '0;
            rr_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q   <= state_d;
            res_q.valid <= lookup_acc;
            res_q.hit   <= lookup_acc && match_any;
            res_q.idx   <= lookup_acc ? match_idx : '0;
            if (inv_all) begin
                valid_q <= '0;
                rr_q    <= '0;
            end else if (refill_acc) begin
                valid_q[victim] <= 1'b1;
                if (!match_any && !free_any) begin
                    rr_q <= idx_inc(rr_q);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (refill_acc) begin
            tag_q[victim] <= refill_vpn;
        end
    end

    assign res_valid = res_q.valid;
    assign res_hit   = res_q.hit;
    assign res_idx   = res_q.idx;
    assign ram_we    = refill_acc;
    assign ram_addr  = refill_acc ? victim : res_q.idx;

endmodule

// File: tb/tb_tlb_tag_cam.sv
// Directed bench for tlb_tag_cam: reset, fill, hit, victim
// selection, contention, invalidate and reset mid-result.
module tb_tlb_tag_cam;

    logic        clk;
    logic        clrn;
    logic        inv_all;
    logic        lookup_valid;
    logic        lookup_ready;
    logic [19:0] lookup_vpn;
    logic        res_valid;
    logic        res_hit;
    logic [2:0]  res_idx;
    logic        refill_valid;
    logic        refill_ready;
    logic [19:0] refill_vpn;
    logic [2:0]  ram_addr;
    logic        ram_we;

    int n_cmp;
    int n_err;

    tlb_tag_cam dut (
        .clk          (clk),
        .clrn         (clrn),
        .inv_all      (inv_all),
        .lookup_valid (lookup_valid),
        .lookup_ready (lookup_ready),
        .lookup_vpn   (lookup_vpn),
        .res_valid    (res_valid),
        .res_hit      (res_hit),
        .res_idx      (res_idx),
        .refill_valid (refill_valid),
        .refill_ready (refill_ready),
        .refill_vpn   (refill_vpn),
        .ram_addr     (ram_addr),
        .ram_we       (ram_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        clrn = 1'b0;
        inv_all = 1'b0;
        lookup_valid = 1'b1;
        lookup_vpn = 20'h12345;
        refill_valid = 1'b1;
        refill_vpn = 20'h00001;
        #1;
        n_cmp++;
        if ({lookup_ready, refill_ready, ram_we} !== 3'b000) begin
            n_err++;
            $display("FAIL rst_ready: got %b want 000",
                     {lookup_ready, refill_ready, ram_we});
        end
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({res_valid, res_hit, res_idx, ram_addr, ram_we} !== 9'd0) begin
            n_err++;
            $display("FAIL rst_out: got %b want 0",
                     {res_valid, res_hit, res_idx, ram_addr, ram_we});
        end
        clrn = 1'b1;
        lookup_valid = 1'b0;
        refill_valid = 1'b0;
    endtask

    task automatic test_miss();
        @(negedge clk);
        lookup_valid = 1'b1;
        lookup_vpn = 20'h12345;
        #1;
        n_cmp++;
        if ({lookup_ready, ram_we} !== 2'b10) begin
            n_err++;
            $display("FAIL miss_acc: got %b want 10", {lookup_ready, ram_we});
        end
        @(negedge clk);
        lookup_valid = 1'b0;
        #1;
        n_cmp++;
        if ({res_valid, res_hit, res_idx, ram_we} !== 6'b10_000_0) begin
            n_err++;
            $display("FAIL miss_res: got %b want 100000",
                     {res_valid, res_hit, res_idx, ram_we});
        end
    endtask

    task automatic test_fill_hit();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            refill_valid = 1'b1;
            refill_vpn = 20'h00010 + 20'(i);
            #1;
            n_cmp++;
            if ({ram_we, ram_addr} !== {1'b1, 3'(i)}) begin
                n_err++;
                $display("FAIL fill_%0d: got we/addr %b want 1/%0d",
                         i, {ram_we, ram_addr}, i);
            end
        end
        @(negedge clk);
        refill_valid = 1'b0;
        lookup_valid = 1'b1;
        lookup_vpn = 20'h00015;
        @(negedge clk);
        lookup_valid = 1'b0;
        #1;
        n_cmp++;
        if ({res_valid, res_hit, res_idx, ram_addr} !== 8'b1_1_101_101) begin
            n_err++;
            $display("FAIL hit15: got %b want 11101101",
                     {res_valid, res_hit, res_idx, ram_addr});
        end
    endtask

    task automatic test_duplicate();
        @(negedge clk);
        refill_valid = 1'b1;
        refill_vpn = 20'h00013;
        #1;
        n_cmp++;
        if ({ram_we, ram_addr} !== 4'b1_011) begin
            n_err++;
            $display("FAIL dup_victim: got %b want 1011", {ram_we, ram_addr});
        end
        @(negedge clk);
        refill_valid = 1'b0;
        lookup_valid = 1'b1;
        lookup_vpn = 20'h00013;
        @(negedge clk);
        lookup_valid = 1'b0;
        #1;
        n_cmp++;
        if ({res_valid, res_hit, res_idx} !== 5'b1_1_011) begin
            n_err++;
            $display("FAIL dup_hit: got %b want 11011",
                     {res_valid, res_hit, res_idx});
        end
    endtask

    task automatic test_rr_wrap();
        logic [19:0] vpns [10];
        logic [2:0]  exp  [10];
        vpns[0] = 20'h000A0; exp[0] = 3'd0;
        vpns[1] = 20'h000A1; exp[1] = 3'd1;
        for (int k = 0; k < 8; k++) begin
            vpns[k+2] = 20'h000B0 + 20'(k);
            exp[k+2]  = 3'((k + 2) % 8);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            refill_valid = 1'b1;
            refill_vpn = vpns[k];
            #1;
            n_cmp++;
            if ({ram_we, ram_addr} !== {1'b1, exp[k]}) begin
                n_err++;
                $display("FAIL rr_%0d: got %b want 1/%0d",
                         k, {ram_we, ram_addr}, exp[k]);
            end
        end
        @(negedge clk);
        refill_valid = 1'b0;
        lookup_valid = 1'b1;
        lookup_vpn = 20'h000B6;
        @(negedge clk);
        lookup_valid = 1'b0;
        #1;
        n_cmp++;
        if ({res_valid, res_hit, res_idx} !== 5'b1_1_000) begin
            n_err++;
            $display("FAIL rr_hitB6: got %b want 11000",
                     {res_valid, res_hit, res_idx});
        end
    endtask

    task automatic test_contention();
        @(negedge clk);
        refill_valid = 1'b1;
        refill_vpn = 20'h000C0;
        lookup_valid = 1'b1;
        lookup_vpn = 20'h000C0;
        #1;
        n_cmp++;
        if ({lookup_ready, refill_ready, ram_we, ram_addr} !== 6'b0_1_1_010) begin
            n_err++;
            $display("FAIL cont_both: got %b want 011010",
                     {lookup_ready, refill_ready, ram_we, ram_addr});
        end
        @(negedge clk);
        refill_valid = 1'b0;
        #1;
        n_cmp++;
        if ({lookup_ready, res_valid} !== 2'b10) begin
            n_err++;
            $display("FAIL cont_wait: got %b want 10", {lookup_ready, res_valid});
        end
        @(negedge clk);
        lookup_valid = 1'b0;
        #1;
        n_cmp++;
        if ({res_valid, res_hit, res_idx} !== 5'b1_1_010) begin
            n_err++;
            $display("FAIL cont_hit: got %b want 11010",
                     {res_valid, res_hit, res_idx});
        end
        @(negedge clk);
        lookup_valid = 1'b1;
        lookup_vpn = 20'h000B1;
        @(negedge clk);
        lookup_valid = 1'b0;
        refill_valid = 1'b1;
        refill_vpn = 20'h000D0;
        #1;
        n_cmp++;
        if ({refill_ready, ram_we, ram_addr, res_hit} !== 6'b0_0_011_1) begin
            n_err++;
            $display("FAIL look_block: got %b want 000111",
                     {refill_ready, ram_we, ram_addr, res_hit});
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if ({refill_ready, ram_we, ram_addr} !== 5'b1_1_011) begin
            n_err++;
            $display("FAIL look_release: got %b want 11011",
                     {refill_ready, ram_we, ram_addr});
        end
        @(negedge clk);
        refill_valid = 1'b0;
    endtask

    task automatic test_inv_all();
        @(negedge clk);
        inv_all = 1'b1;
        refill_valid = 1'b1;
        refill_vpn = 20'h000E0;
        lookup_valid = 1'b1;
        lookup_vpn = 20'h000B6;
        #1;
        n_cmp++;
        if ({lookup_ready, refill_ready, ram_we} !== 3'b000) begin
            n_err++;
            $display("FAIL inv_block: got %b want 000",
                     {lookup_ready, refill_ready, ram_we});
        end
        @(negedge clk);
        inv_all = 1'b0;
        refill_valid = 1'b0;
        #1;
        n_cmp++;
        if (res_valid !== 1'b0) begin
            n_err++;
            $display("FAIL inv_nores: got %b want 0", res_valid);
        end
        @(negedge clk);
        lookup_valid = 1'b0;
        #1;
        n_cmp++;
        if ({res_valid, res_hit, res_idx} !== 5'b1_0_000) begin
            n_err++;
            $display("FAIL inv_miss: got %b want 10000",
                     {res_valid, res_hit, res_idx});
        end
        @(negedge clk);
        refill_valid = 1'b1;
        refill_vpn = 20'h000F0;
        #1;
        n_cmp++;
        if ({ram_we, ram_addr} !== 4'b1_000) begin
            n_err++;
            $display("FAIL inv_refill0: got %b want 1000", {ram_we, ram_addr});
        end
        @(negedge clk);
        refill_vpn = 20'h000F1;
        #1;
        n_cmp++;
        if ({ram_we, ram_addr} !== 4'b1_001) begin
            n_err++;
            $display("FAIL inv_refill1: got %b want 1001", {ram_we, ram_addr});
        end
        @(negedge clk);
        refill_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        lookup_valid = 1'b1;
        lookup_vpn = 20'h000F1;
        @(negedge clk);
        lookup_valid = 1'b0;
        clrn = 1'b0;
        refill_valid = 1'b1;
        refill_vpn = 20'h00099;
        #1;
        n_cmp++;
        if ({res_valid, res_idx, ram_we, refill_ready} !== 6'b1_001_0_0) begin
            n_err++;
            $display("FAIL mid_pre: got %b want 100100",
                     {res_valid, res_idx, ram_we, refill_ready});
        end
        @(negedge clk);
        clrn = 1'b1;
        refill_valid = 1'b0;
        #1;
        n_cmp++;
        if ({res_valid, ram_addr, ram_we} !== 5'b0) begin
            n_err++;
            $display("FAIL mid_post: got %b want 00000",
                     {res_valid, ram_addr, ram_we});
        end
        lookup_valid = 1'b1;
        lookup_vpn = 20'h000F0;
        @(negedge clk);
        lookup_valid = 1'b0;
        #1;
        n_cmp++;
        if ({res_valid, res_hit} !== 2'b10) begin
            n_err++;
            $display("FAIL mid_miss: got %b want 10", {res_valid, res_hit});
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_miss();
        test_fill_hit();
        test_duplicate();
        test_rr_wrap();
        test_contention();
        test_inv_all();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
